// File: rtl/imem_port_arbiter.sv
// Shares a single-port instruction memory between the fetch path and the program loader.
// Optional macro IMEM_ARB_RR_EN selects round-robin arbitration instead of loader priority.
module imem_port_arbiter #(
  parameter int unsigned addr_width = 32,
  parameter int unsigned data_width = 32,
  parameter int unsigned max_wait   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req,
  input  logic [addr_width-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_valid,
  output logic [data_width-1:0] f_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [addr_width-1:0] l_addr,
  input  logic [data_width-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_done,
  output logic [data_width-1:0] l_rdata,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [data_width-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic                  sel_loader_q, sel_loader_d;
  logic                  we_q, we_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [data_width-1:0] wdata_q, wdata_d;
  logic [data_width-1:0] f_rdata_q, f_rdata_d;
  logic [data_width-1:0] l_rdata_q, l_rdata_d;
  logic                  fetch_wins;

`ifdef IMEM_ARB_RR_EN
  logic last_fetch_q, last_fetch_d;

  // On a tie the side that did not win last time goes first.
  assign fetch_wins = f_req & (~l_req | ~last_fetch_q);
`else
  localparam logic [3:0] MaxWait = 4'(max_wait);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign fetch_wins = f_req & (~l_req | (starve_cnt_q == MaxWait));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sel_loader_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      f_rdata_q    <= '0;
      l_rdata_q    <= '0;
`ifdef IMEM_ARB_RR_EN
      last_fetch_q <= 1'b0;
`else
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sel_loader_q <= sel_loader_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      f_rdata_q    <= f_rdata_d;
      l_rdata_q    <= l_rdata_d;
`ifdef IMEM_ARB_RR_EN
      last_fetch_q <= last_fetch_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_loader_d = sel_loader_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    f_rdata_d    = f_rdata_q;
    l_rdata_d    = l_rdata_q;
`ifdef IMEM_ARB_RR_EN
    last_fetch_d = last_fetch_q;
`else
    starve_cnt_d = starve_cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (f_req | l_req) begin
          state_d      = StAccess;
          sel_loader_d = ~fetch_wins;
          we_d         = ~fetch_wins & l_we;
          addr_d       = fetch_wins ? f_addr : l_addr;
          wdata_d      = l_wdata;
`ifdef IMEM_ARB_RR_EN
          last_fetch_d = fetch_wins;
`else
          if (fetch_wins) begin
            starve_cnt_d = '0;
          end else if (f_req && starve_cnt_q != MaxWait) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
`endif
        end
      end
      StAccess: state_d = StResp;
      StResp: begin
        state_d = StIdle;
        if (!sel_loader_q) begin
          f_rdata_d = mem_rdata;
        end else if (!we_q) begin
          l_rdata_d = mem_rdata;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    f_gnt     = 1'b0;
    l_gnt     = 1'b0;
    f_valid   = 1'b0;
    l_done    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    busy      = 1'b0;
    f_rdata   = f_rdata_q;
    l_rdata   = l_rdata_q;
    case (state_q)
      StAccess: begin
        busy      = 1'b1;
        f_gnt     = ~sel_loader_q;
        l_gnt     = sel_loader_q;
        mem_addr  = addr_q;
        mem_we    = we_q;
        mem_re    = ~we_q;
        mem_wdata = we_q ? wdata_q : '0;
      end
      StResp: begin
        busy    = 1'b1;
        f_valid = ~sel_loader_q;
        l_done  = sel_loader_q;
        // Memory output is registered, so read data is live during this cycle only.
        if (!sel_loader_q) begin
          f_rdata = mem_rdata;
        end else if (!we_q) begin
          l_rdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed and randomized bench for imem_port_arbiter with a registered-read memory model.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, f_gnt, f_valid;
  logic [31:0] f_addr, f_rdata;
  logic        l_req, l_we, l_gnt, l_done;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re, busy;
  logic        load;
  logic [31:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.addr_width(32), .data_width(32), .max_wait(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_valid  (f_valid),
    .f_rdata  (f_rdata),
    .l_req    (l_req),
    .l_we     (l_we),
    .l_addr   (l_addr),
    .l_wdata  (l_wdata),
    .l_gnt    (l_gnt),
    .l_done   (l_done),
    .l_rdata  (l_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] <= (i == 4) ? 32'h0050_0093 : {24'hA5A5A5, 8'(i)};
      end
      mem_rdata <= '0;
    end else begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        fr;
    logic [31:0] fa;
    logic        lr;
    logic        lw;
    logic [31:0] la;
    logic [31:0] lwd;
    logic        fwin;
    logic [31:0] rdata;
    logic        fwin_rr;
    logic [31:0] rdata_rr;
  } vec_t;

  // Entered at the negedge preceding an IDLE cycle; leaves after the RESP cycle.
  task automatic run_vec(input vec_t v);
    logic        fw;
    logic [31:0] rd, ea;
`ifdef IMEM_ARB_RR_EN
    fw = v.fwin_rr;
    rd = v.rdata_rr;
`else
    fw = v.fwin;
    rd = v.rdata;
`endif
    ea = fw ? v.fa : v.la;
    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    f_req = v.fr; f_addr = v.fa;
    l_req = v.lr; l_we = v.lw; l_addr = v.la; l_wdata = v.lwd;
    @(negedge clk);
    chk1("acc_f_gnt", f_gnt, fw);
    chk1("acc_l_gnt", l_gnt, ~fw);
    chk32("acc_mem_addr", mem_addr, ea);
    chk1("acc_mem_we", mem_we, ~fw & v.lw);
    chk1("acc_mem_re", mem_re, fw | ~v.lw);
    chk1("acc_busy", busy, 1'b1);
    if (!fw && v.lw) chk32("acc_mem_wdata", mem_wdata, v.lwd);
    f_req = 1'b0; l_req = 1'b0;
    @(negedge clk);
    chk1("resp_f_valid", f_valid, fw);
    chk1("resp_l_done", l_done, ~fw);
    chk1("resp_busy", busy, 1'b1);
    if (fw) chk32("resp_f_rdata", f_rdata, rd);
    else if (!v.lw) chk32("resp_l_rdata", l_rdata, rd);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_f_gnt"}, f_gnt, 1'b0);
    chk1({tag, "_l_gnt"}, l_gnt, 1'b0);
    chk1({tag, "_f_valid"}, f_valid, 1'b0);
    chk1({tag, "_l_done"}, l_done, 1'b0);
    chk1({tag, "_mem_we"}, mem_we, 1'b0);
    chk1({tag, "_mem_re"}, mem_re, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk32({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk32({tag, "_f_rdata"}, f_rdata, 32'h0);
    chk32({tag, "_l_rdata"}, l_rdata, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    vec_t vr;
    logic exp_order[10];
    logic got_order[10];
    int   ngnt;
    logic prev_f, prev_l;

    //            fr  fa            lr  lw  la            lwd           fwin rdata         rr   rdata_rr
    vecs[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0050_0093, 1'b1, 32'h0050_0093};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'hA5A5_A510};
    vecs[5] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hA5A5_A511, 1'b1, 32'hA5A5_A511};
    vecs[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h48, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
    vecs[8] = '{1'b1, 32'h4C, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0050_0093, 1'b0, 32'h0050_0093};
    vecs[9] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_F003, 32'h0, 1'b0, 32'hA5A5_A500,
                1'b0, 32'hA5A5_A500};

    rst = 1'b1; load = 1'b1;
    f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    repeat (3) @(negedge clk);
    load = 1'b0;
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Read data registers hold their last captured values between pulses.
    @(negedge clk);
    chk32("hold_f_rdata", f_rdata, 32'hCAFE_F00D);
    chk32("hold_l_rdata", l_rdata, 32'hA5A5_A500);

    // Reset in the ACCESS cycle of a fetch.
    f_req = 1'b1; f_addr = 32'h10;
    @(negedge clk);
    chk1("rstmid_gnt", f_gnt, 1'b1);
    rst = 1'b1; f_req = 1'b0;
    @(negedge clk);
    chk_all_zero("rstmid");
    rst = 1'b0;
    vr = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    run_vec(vr);

    // Contention: both requests held from a fresh reset.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
`ifdef IMEM_ARB_RR_EN
      exp_order[i] = (i % 2 == 0);
`else
      exp_order[i] = (i % 5 == 4);
`endif
      got_order[i] = 1'b0;
    end
    f_req = 1'b1; f_addr = 32'h10; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h20;
    ngnt = 0;
    for (int c = 0; c < 100 && ngnt < 10; c++) begin
      @(negedge clk);
      if (f_gnt || l_gnt) begin
        got_order[ngnt] = f_gnt;
`ifndef IMEM_ARB_RR_EN
        if (f_gnt) chk32("starve_clear", 32'(dut.starve_cnt_q), 32'h0);
`endif
        ngnt++;
      end
    end
    chk32("contention_grant_count", ngnt, 32'd10);
    for (int i = 0; i < 10; i++) chk1($sformatf("grant_order_%0d", i), got_order[i], exp_order[i]);
    f_req = 1'b0; l_req = 1'b0;
    repeat (3) @(negedge clk);

    // Random traffic: exclusivity and gnt-to-response pairing.
    prev_f = 1'b0; prev_l = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      chk1("rnd_we_re_excl", mem_we & mem_re, 1'b0);
      chk1("rnd_gnt_excl", f_gnt & l_gnt, 1'b0);
      chk1("rnd_gnt_per_access", f_gnt | l_gnt, mem_we | mem_re);
      chk1("rnd_f_valid_follow", f_valid, prev_f);
      chk1("rnd_l_done_follow", l_done, prev_l);
      prev_f = f_gnt; prev_l = l_gnt;
      f_req   = 1'($urandom_range(0, 1));
      l_req   = 1'($urandom_range(0, 1));
      l_we    = 1'($urandom_range(0, 1));
      f_addr  = $urandom & 32'h3FC;
      l_addr  = $urandom & 32'h3FC;
      l_wdata = $urandom;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port instruction memory between two requesters: the fetch path (read-only) and the program loader (read/write, e.g. UART boot loader).
- Sits between the requesters and the memory array.
- Registers every memory access and returns read data with a fixed latency.
- Loader has priority; a starvation counter guarantees fetch forward progress.

Parameters:
- addr_width, 32, width of all address buses
- data_width, 32, width of data buses (one instruction)
- max_wait, 4, consecutive lost arbitrations after which fetch is forced to win (1..15)

Ports:
- clk  in  1  global clock
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch request; held high with f_addr stable until f_gnt
- f_addr  in  addr_width  fetch byte address
- f_gnt  out  1  one-cycle pulse: fetch access issued this cycle
- f_valid  out  1  one-cycle pulse: f_rdata holds fetched instruction
- f_rdata  out  data_width  fetched instruction
- l_req  in  1  loader request; held with l_we/l_addr/l_wdata stable until l_gnt
- l_we  in  1  1 = write, 0 = read
- l_addr  in  addr_width  loader byte address
- l_wdata  in  data_width  loader write data
- l_gnt  out  1  one-cycle pulse: loader access issued this cycle
- l_done  out  1  one-cycle pulse: write completed or read data valid
- l_rdata  out  data_width  loader read data
- mem_addr  out  addr_width  memory address
- mem_wdata  out  data_width  memory write data
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_rdata  in  data_width  memory read data, registered (valid the cycle after mem_re)
- busy  out  1  high in ACCESS or RESP

Behaviour:
- Reset: state IDLE, starve counter 0; all outputs 0.
- FSM states:
  - IDLE: arbitrate. Winner's request fields are latched, then ACCESS. No request stays in IDLE.
  - ACCESS (1 cycle): drive mem_addr/mem_we/mem_re from the latched fields; pulse the winner's gnt; then RESP.
  - RESP (1 cycle): fetch read: f_valid=1, f_rdata=mem_rdata. Loader read: l_done=1, l_rdata=mem_rdata. Loader write: l_done=1. Then IDLE.
- Timing: request seen in IDLE at cycle N → gnt at N+1 → valid/done at N+2. Next arbitration at N+3. Peak throughput is one access per 3 cycles.
- mem_re=1 only for reads in ACCESS; mem_we=1 only for loader writes in ACCESS. mem_we and mem_re are never both high.
- Arbitration, fixed priority: l_req beats f_req, except when starve_cnt == max_wait, in which case fetch wins.
- starve_cnt:
  - increments (saturating at max_wait) when fetch loses with f_req high;
  - clears when fetch wins;
  - holds when f_req is low.
- Simultaneous requests with starve_cnt < max_wait: loader wins; the fetch request stays pending. A requester that drops req before gnt is legal and loses nothing.
- Outputs f_rdata/l_rdata hold their last value outside valid/done pulses.
- rst in any state: next cycle is IDLE with all pulses low. An in-flight access produces no valid/done pulse. A write already issued in ACCESS is not undone.
- Addresses pass through unmodified; no alignment check.

Optional Feature:
- Macro IMEM_ARB_RR_EN.
- Defined: round-robin arbitration. A last-winner bit (reset 0 = loader) decides: when both request, the requester that did not win last time wins. starve_cnt and max_wait are unused.
- Undefined: fixed loader priority with the starvation counter as above.

Test Plan:
- Lone fetch: rst low, f_req=1, f_addr=0x10, memory word 0x00500093 → f_gnt at +1, mem_re=1, mem_addr=0x10; f_valid at +2 with f_rdata=0x00500093; busy high 2 cycles.
- Loader write then fetch read-back: l_req=1, l_we=1, l_addr=0x20, l_wdata=0xDEADBEEF → mem_we pulse with that addr/data, l_done at +2. Then fetch 0x20 → f_rdata=0xDEADBEEF.
- Contention, fixed priority, max_wait=4: f_req and l_req held high continuously → grant order L,L,L,L,F,L,L,L,L,F. starve_cnt reads 0 after each fetch grant.
- Reset mid-access: rst asserted in the ACCESS cycle of a fetch → no f_valid; next cycle IDLE, all outputs 0; a new fetch completes with normal 2-cycle latency.
- Read/write exclusivity: random req/we stimulus for 1000 cycles → mem_we & mem_re never both 1; exactly one gnt per access; every gnt followed by exactly one valid/done 1 cycle later.
- With IMEM_ARB_RR_EN defined, both requests held → grants strictly alternate F,L,F,L starting with F after reset.
